// File: rtl/mrd_pkg.sv
// mrd_pkg: shared state codes, stage limit and radix type for the mixed-radix DFT control sequencer.
package mrd_pkg;

    localparam int MAX_STAGES = 6;

    typedef enum logic [1:0] {
        SINK   = 2'b00,
        READ   = 2'b01,
        WRITE  = 2'b10,
        SOURCE = 2'b11
    } state_t;

    typedef logic [2:0] radix_t;

    // A zero stage count still needs one pass; oversized counts saturate at the table depth.
    function automatic logic [2:0] clamp_nstages(input logic [2:0] n, input int max_stages);
        return (n == 3'd0) ? 3'd1 : (int'(n) > max_stages) ? 3'(max_stages) : n;
    endfunction

endpackage

// File: rtl/mrd_phase_watch.sv
// mrd_phase_watch: arm-then-complete detector on a phase busy flag, plus a per-phase watchdog.
module mrd_phase_watch #(
    parameter int W_TMO = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic flag,
    input  logic count,
    output logic fall,
    output logic expired
);

    logic             armed;
    logic [W_TMO-1:0] cnt;

    // A phase only completes once its flag has been seen high and then drops.
    assign fall    = armed && !flag;
    assign expired = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (clear) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else begin
            armed <= armed || flag;
            cnt   <= count ? cnt + W_TMO'(1) : cnt;
        end
    end

endmodule

// File: rtl/mrd_ctrl_seq.sv
// mrd_ctrl_seq: sequences SINK -> (READ -> WRITE) x nstages -> SOURCE for a mixed-radix DFT memory,
// latching the block configuration on sink_sop and aborting stuck phases via a watchdog.
module mrd_ctrl_seq #(
    parameter int MAX_STAGES = mrd_pkg::MAX_STAGES,
    parameter int W_PTS      = 12,
    parameter int W_TMO      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sink_sop,
    input  logic [W_PTS-1:0]        sink_dftpts,
    input  logic                    sink_ongoing,
    input  logic                    rd_ongoing,
    input  logic                    wr_ongoing,
    input  logic                    source_ongoing,
    input  logic [2:0]              cfg_nstages,
    input  logic [MAX_STAGES*3-1:0] cfg_nf,
    output logic [1:0]              state,
    output logic [2:0]              current_stage,
    output logic [MAX_STAGES*3-1:0] nf,
    output logic [W_PTS-1:0]        dftpts,
    output logic                    done,
    output logic                    err_sop,
    output logic                    err_tmo
);

    import mrd_pkg::*;

    state_t     st;
    logic [2:0] nstages;
    logic       loaded;
    logic       sop_sink;
    logic       flag;
    logic       fall;
    logic       expired;
    logic       tmo;
    logic       clear;
    logic       last;

    assign state = st;

    // SINK ignores sink_ongoing until a block has been announced by sink_sop.
    always_comb begin
        sop_sink = sink_sop && st == SINK;
        flag     = (st == SINK)  ? sink_ongoing && loaded :
                   (st == READ)  ? rd_ongoing :
                   (st == WRITE) ? wr_ongoing : source_ongoing;
        tmo      = st != SINK && expired;
        clear    = sop_sink || tmo || fall;
        last     = {1'b0, current_stage} + 4'd1 >= {1'b0, nstages};
    end

    mrd_phase_watch #(
        .W_TMO(W_TMO)
    ) u_watch (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .flag   (flag),
        .count  (st != SINK),
        .fall   (fall),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= SINK;
            current_stage <= '0;
            nf            <= '0;
            dftpts        <= '0;
            nstages       <= '0;
            loaded        <= 1'b0;
            done          <= 1'b0;
            err_sop       <= 1'b0;
            err_tmo       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sink_sop && st != SINK)
                err_sop <= 1'b1;
            // A new sop wins over a completing SINK phase: the block restarts on the new config.
            if (sop_sink) begin
                dftpts  <= sink_dftpts;
                nf      <= cfg_nf;
                nstages <= clamp_nstages(cfg_nstages, MAX_STAGES);
                loaded  <= 1'b1;
            end else if (tmo) begin
                err_tmo       <= 1'b1;
                st            <= SINK;
                current_stage <= '0;
                loaded        <= 1'b0;
            end else if (fall) begin
                case (st)
                    SINK: begin
                        st            <= READ;
                        current_stage <= '0;
                        loaded        <= 1'b0;
                    end
                    READ: st <= WRITE;
                    WRITE: begin
                        st            <= last ? SOURCE : READ;
                        current_stage <= last ? current_stage : current_stage + 3'd1;
                    end
                    SOURCE: begin
                        st            <= SINK;
                        current_stage <= '0;
                        done          <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
